// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// Holds the arbiter state encoding, size limits and the address one-hot decoder.
package reg_arb_pkg;

   localparam int MAX_NREQ  = 8;
   localparam int MAX_NREGS = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   // One-hot decode over the largest supported bank; callers truncate to NREGS.
   function automatic logic [MAX_NREGS-1:0] addr_onehot(input logic [3:0] addr);
      logic [MAX_NREGS-1:0] vec;
      vec       = '0;
      vec[addr] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational requester picker: round-robin from ptr, or a lowest-index
// priority encoder when REG_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
`ifndef REG_ARB_FIXED_PRIO_EN
   input  logic [IW-1:0]   ptr,
`endif
   output logic            valid,
   output logic [IW-1:0]   win
);

   // Scan requesters in search order; the first active one wins.
   always_comb begin
      int   idx;
      logic hit;
      idx   = 0;
      hit   = 1'b0;
      valid = 1'b0;
      win   = '0;
      for (int i = 0; i < NREQ; i++) begin
`ifdef REG_ARB_FIXED_PRIO_EN
         idx = i;
`else
         idx = (int'(ptr) + i) % NREQ;
`endif
         hit   = req[idx] & ~valid;
         win   = hit ? IW'(idx) : win;
         valid = valid | hit;
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares one write port of a register bank among NREQ requesters.
// Define REG_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module reg_bank_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NREGS = 8,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       gnt,
   output logic [NREGS-1:0]      reg_en,
   output logic [WIDTH-1:0]      reg_d,
   output logic                  addr_err,
   output logic                  busy
);

   localparam int IW = $clog2(NREQ);

   if (NREQ > MAX_NREQ || NREGS > MAX_NREGS) begin : g_size_check
      $error("reg_bank_arbiter: NREQ or NREGS exceeds supported maximum");
   end

   state_t            state_r, state_n;
   logic [NREQ-1:0]   gnt_r, gnt_n;
   logic [NREGS-1:0]  reg_en_r, reg_en_n;
   logic [WIDTH-1:0]  reg_d_r, reg_d_n;
   logic              addr_err_r, addr_err_n;
   logic              busy_r, busy_n;
   logic              pick_valid_s;
   logic [IW-1:0]     pick_win_s;
   logic [AW-1:0]     addr_s;
   logic [WIDTH-1:0]  data_s;
`ifndef REG_ARB_FIXED_PRIO_EN
   logic [IW-1:0]     rr_ptr_r, rr_ptr_n;
   logic [IW-1:0]     win_r, win_n;
`endif

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req),
`ifndef REG_ARB_FIXED_PRIO_EN
      .ptr   (rr_ptr_r),
`endif
      .valid (pick_valid_s),
      .win   (pick_win_s)
   );

   assign addr_s = req_addr[int'(pick_win_s)*AW +: AW];
   assign data_s = req_data[int'(pick_win_s)*WIDTH +: WIDTH];

   // Next-state and next-output logic; an out-of-range address decodes to no enable.
   always_comb begin
      state_n    = state_r;
      gnt_n      = '0;
      reg_en_n   = '0;
      reg_d_n    = reg_d_r;
      addr_err_n = 1'b0;
      busy_n     = 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
      rr_ptr_n   = rr_ptr_r;
      win_n      = win_r;
`endif
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_n             = WRITE;
               gnt_n[pick_win_s]   = 1'b1;
               reg_en_n            = NREGS'(addr_onehot(4'(addr_s)));
               addr_err_n          = ~|reg_en_n;
               reg_d_n             = data_s;
               busy_n              = 1'b1;
`ifndef REG_ARB_FIXED_PRIO_EN
               win_n               = pick_win_s;
`endif
            end else begin
               state_n = IDLE;
            end
         end
         WRITE: begin
            state_n = IDLE;
`ifndef REG_ARB_FIXED_PRIO_EN
            rr_ptr_n = (win_r == IW'(NREQ - 1)) ? '0 : win_r + 1'b1;
`endif
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_r    <= IDLE;
         gnt_r      <= '0;
         reg_en_r   <= '0;
         reg_d_r    <= '0;
         addr_err_r <= 1'b0;
         busy_r     <= 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
         rr_ptr_r   <= '0;
         win_r      <= '0;
`endif
      end else begin
         state_r    <= state_n;
         gnt_r      <= gnt_n;
         reg_en_r   <= reg_en_n;
         reg_d_r    <= reg_d_n;
         addr_err_r <= addr_err_n;
         busy_r     <= busy_n;
`ifndef REG_ARB_FIXED_PRIO_EN
         rr_ptr_r   <= rr_ptr_n;
         win_r      <= win_n;
`endif
      end
   end

   assign gnt      = gnt_r;
   assign reg_en   = reg_en_r;
   assign reg_d    = reg_d_r;
   assign addr_err = addr_err_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter: a default 8-register
// instance plus a 6-register instance for out-of-range addresses.
module tb_reg_bank_arbiter;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  req;
   logic [11:0] req_addr;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic [7:0]  reg_en;
   logic [7:0]  reg_d;
   logic        addr_err;
   logic        busy;

   logic [3:0]  req6;
   logic [11:0] req_addr6;
   logic [31:0] req_data6;
   logic [3:0]  gnt6;
   logic [5:0]  reg_en6;
   logic [7:0]  reg_d6;
   logic        addr_err6;
   logic        busy6;

   logic [7:0]  bank  [8] = '{default: 8'h00};
   logic [7:0]  bank6 [6] = '{default: 8'h00};

   int checks = 0;
   int errors = 0;

   reg_bank_arbiter #(.NREQ(4), .NREGS(8), .WIDTH(8)) dut (
      .clk(clk), .clr(clr), .req(req), .req_addr(req_addr), .req_data(req_data),
      .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d), .addr_err(addr_err), .busy(busy)
   );

   reg_bank_arbiter #(.NREQ(4), .NREGS(6), .WIDTH(8)) dut6 (
      .clk(clk), .clr(clr), .req(req6), .req_addr(req_addr6), .req_data(req_data6),
      .gnt(gnt6), .reg_en(reg_en6), .reg_d(reg_d6), .addr_err(addr_err6), .busy(busy6)
   );

   // Bank models: capture reg_d into the enabled register at each rising edge.
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) if (reg_en[i]) bank[i] <= reg_d;
      for (int i = 0; i < 6; i++) if (reg_en6[i]) bank6[i] <= reg_d6;
   end

   task automatic apply_reset;
      req = 4'b0000; req6 = 4'b0000;
      clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b1;
   endtask

   task automatic test_reset;
      req = 4'b0000; req6 = 4'b0000;
      req_addr = 12'h000; req_data = 32'h0; req_addr6 = 12'h000; req_data6 = 32'h0;
      clr = 1'b0;
      #3;
      checks++;
      if ({gnt, reg_en, reg_d, addr_err, busy} !== 22'h0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", {gnt, reg_en, reg_d, addr_err, busy});
      end
      apply_reset;
      @(posedge clk); #1;
      checks++;
      if ({gnt, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_idle: gnt=%b busy=%b expected 0", gnt, busy);
      end
   endtask

   task automatic test_single;
      apply_reset;
      req_addr[3 +: 3] = 3'd3;
      req_data[8 +: 8] = 8'hA5;
      req = 4'b0010;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0010 || reg_en !== 8'b0000_1000 || reg_d !== 8'hA5 || busy !== 1'b1 || addr_err !== 1'b0) begin
         errors++;
         $display("FAIL single_write: gnt=%b reg_en=%b reg_d=%h busy=%b err=%b expected 0010 00001000 a5 1 0",
                  gnt, reg_en, reg_d, busy, addr_err);
      end
      req = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0000 || reg_en !== 8'h00 || busy !== 1'b0) begin
         errors++; $display("FAIL single_after: gnt=%b reg_en=%b busy=%b expected 0", gnt, reg_en, busy);
      end
      checks++;
      if (bank[3] !== 8'hA5) begin
         errors++; $display("FAIL single_bank: bank[3]=%h expected a5", bank[3]);
      end
   endtask

`ifndef REG_ARB_FIXED_PRIO_EN
   task automatic test_full_contention;
      logic [3:0] exp_gnt;
      logic [7:0] exp_en;
      apply_reset;
      for (int i = 0; i < 4; i++) begin
         req_addr[i*3 +: 3] = 3'(i + 4);
         req_data[i*8 +: 8] = 8'h10 + 8'(i);
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_gnt = 4'b0001 << (k % 4);
         exp_en  = 8'h10 << (k % 4);
         @(posedge clk); #1;
         checks++;
         if (gnt !== exp_gnt || reg_en !== exp_en || reg_d !== 8'h10 + 8'(k % 4) || !$onehot(reg_en)) begin
            errors++;
            $display("FAIL contention_grant%0d: gnt=%b reg_en=%b reg_d=%h expected %b %b %h",
                     k, gnt, reg_en, reg_d, exp_gnt, exp_en, 8'h10 + 8'(k % 4));
         end
         req = 4'b1111;
         @(posedge clk); #1;
         checks++;
         if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL contention_idle%0d: gnt=%b busy=%b expected 0000 0", k, gnt, busy);
         end
         req = 4'b1111 & ~exp_gnt;
      end
      req = 4'b0000;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap_skip;
      apply_reset;
      req = 4'b0100;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0100) begin
         errors++; $display("FAIL wrap_first: gnt=%b expected 0100", gnt);
      end
      req = 4'b0000;
      @(posedge clk); #1;
      req = 4'b0101;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0001) begin
         errors++; $display("FAIL wrap_to_zero: gnt=%b expected 0001", gnt);
      end
      @(posedge clk); #1;
      req = 4'b0100;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0100) begin
         errors++; $display("FAIL wrap_then_two: gnt=%b expected 0100", gnt);
      end
      req = 4'b0000;
      @(posedge clk); #1;
   endtask
`else
   task automatic test_fixed_prio;
      logic [3:0] exp_gnt;
      apply_reset;
      req = 4'b1001;
      for (int k = 0; k < 8; k++) begin
         exp_gnt = (k % 2 == 0) ? 4'b0001 : 4'b0000;
         @(posedge clk); #1;
         checks++;
         if (gnt !== exp_gnt) begin
            errors++; $display("FAIL fixed_prio%0d: gnt=%b expected %b", k, gnt, exp_gnt);
         end
      end
      req = 4'b0000;
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_out_of_range;
      apply_reset;
      req_addr6[0 +: 3] = 3'd5;
      req_data6[0 +: 8] = 8'h3C;
      req_addr6[3 +: 3] = 3'd7;
      req_data6[8 +: 8] = 8'hFF;
      req6 = 4'b0001;
      @(posedge clk); #1;
      checks++;
      if (gnt6 !== 4'b0001 || reg_en6 !== 6'b10_0000 || addr_err6 !== 1'b0) begin
         errors++; $display("FAIL oor_last_valid: gnt=%b reg_en=%b err=%b expected 0001 100000 0", gnt6, reg_en6, addr_err6);
      end
      req6 = 4'b0000;
      @(posedge clk); #1;
      req6 = 4'b0010;
      @(posedge clk); #1;
      checks++;
      if (gnt6 !== 4'b0010 || reg_en6 !== 6'b00_0000 || addr_err6 !== 1'b1 || busy6 !== 1'b1 || reg_d6 !== 8'hFF) begin
         errors++;
         $display("FAIL oor_error: gnt=%b reg_en=%b err=%b busy=%b reg_d=%h expected 0010 000000 1 1 ff",
                  gnt6, reg_en6, addr_err6, busy6, reg_d6);
      end
      req6 = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (addr_err6 !== 1'b0 || bank6[5] !== 8'h3C || bank6[4] !== 8'h00 || bank6[0] !== 8'h00) begin
         errors++;
         $display("FAIL oor_bank: err=%b bank5=%h bank4=%h bank0=%h expected 0 3c 00 00",
                  addr_err6, bank6[5], bank6[4], bank6[0]);
      end
   endtask

   task automatic test_reset_mid;
      apply_reset;
      req_addr[0 +: 3] = 3'd1; req_data[0 +: 8]  = 8'h11;
      req_addr[3 +: 3] = 3'd0; req_data[8 +: 8]  = 8'h22;
      req_addr[9 +: 3] = 3'd2; req_data[24 +: 8] = 8'h77;
      req = 4'b0010;
      @(posedge clk); #1;
      req = 4'b0000;
      @(posedge clk); #1;
      req = 4'b1000;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b1000 || reg_en !== 8'b0000_0100 || busy !== 1'b1) begin
         errors++; $display("FAIL midreset_pre: gnt=%b reg_en=%b busy=%b expected 1000 00000100 1", gnt, reg_en, busy);
      end
      #2 clr = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0000 || reg_en !== 8'h00 || busy !== 1'b0 || reg_d !== 8'h00) begin
         errors++; $display("FAIL midreset_clear: gnt=%b reg_en=%b busy=%b reg_d=%h expected 0", gnt, reg_en, busy, reg_d);
      end
      req = 4'b1001;
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (gnt !== 4'b0001 || reg_en !== 8'b0000_0010 || reg_d !== 8'h11) begin
         errors++; $display("FAIL midreset_after: gnt=%b reg_en=%b reg_d=%h expected 0001 00000010 11", gnt, reg_en, reg_d);
      end
      checks++;
      if (bank[2] !== 8'h00) begin
         errors++; $display("FAIL midreset_bank: bank[2]=%h expected 00", bank[2]);
      end
      req = 4'b0000;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_single;
`ifndef REG_ARB_FIXED_PRIO_EN
      test_full_contention;
      test_wrap_skip;
`else
      test_fixed_prio;
`endif
      test_out_of_range;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
